calc_op_sequencer: RTL
======================

// Module: calc_op_sequencer
// PURPOSE
//  Control FSM between the sw/bt inputs and the calculator datapath (add/sub/mul/div_N/bin2BCD).
//  Captures operands and the operation on any input change and issues start pulses to the divider and BCD converter.
//  Waits for each done handshake, then latches the BCD digits and the error/dp/blank flags for disp_controll.
//  Replaces the free-running 256-cycle div start and the 100 Hz BCD start with one request/done handshake.
// PARAMETERS
//  bits        8    datapath width of result/operands to div_N and bin2BCD
//  TIMEOUT_CYC 255  max cycles to wait for div_done or bcd_done before flagging error (8-bit counter)
//  REFRESH_CYC 16   AUTO_REFRESH_EN only: idle cycles between forced re-evaluations
// PORTS
//  clk16M    in   1     system clock, 16 MHz
//  rst       in   1     synchronous, active-low reset
//  sw        in   8     operands: sw[7:4]=a, sw[3:0]=b
//  bt        in   4     op select, one-hot: 0001 add, 0010 sub, 0100 mul, 1000 div
//  sub_err   in   1     subtractor negative-result flag (combinational on op_a/op_b)
//  div_err   in   1     divider divide-by-zero flag, valid with div_done
//  div_done  in   1     one-cycle pulse, divider result valid
//  bcd_done  in   1     one-cycle pulse, bin2BCD tens/ones valid
//  bcd_tens  in   4     BCD tens digit from converter
//  bcd_ones  in   4     BCD ones digit from converter
//  op_a      out  4     registered operand a to datapath
//  op_b      out  4     registered operand b to datapath
//  op_sel    out  4     registered one-hot op to result MPX
//  div_start out  1     one-cycle start pulse to div_N
//  bcd_start out  1     one-cycle start pulse to bin2BCD
//  busy      out  1     high from CAPTURE until result latched
//  res_tens  out  4     latched tens digit to disp_controll dig1
//  res_ones  out  4     latched ones digit to disp_controll dig0
//  err_mask  out  4     {a>9, b>9, e, e}; e = op error, timeout or illegal op
//  dp_mask   out  4     {0, 0, div, 0}
//  blank_mask out 4     {0, 0, bl, bl}; bl = (op_sel==0)
// BEHAVIOUR
//  Reset (rst=0 at a clk16M edge): state=IDLE; all outputs 0; shadow registers sw_q/bt_q = 0.
//  Trigger: in IDLE, {sw,bt} != {sw_q,bt_q}. Any change during busy is ignored until return to IDLE,
//   where the mismatch causes an immediate re-trigger (last value wins; no queue).
//  States:
//   IDLE     -> CAPTURE on trigger.
//   CAPTURE  sw_q/bt_q <= sw/bt; op_a/op_b/op_sel load. One cycle.
//            bt==0 -> DONE with bl=1 and digits 0. bt not one-hot -> DONE with e=1.
//            bt==1000 -> DIV_GO; else -> SETTLE.
//   SETTLE   one cycle for the combinational add/sub/mul result to reach the MPX -> BCD_GO.
//   DIV_GO   div_start=1 for exactly 1 cycle; clear timer -> DIV_WAIT.
//   DIV_WAIT on div_done: capture div_err -> BCD_GO. On timer==TIMEOUT_CYC: e=1 -> DONE.
//   BCD_GO   bcd_start=1 for 1 cycle; clear timer -> BCD_WAIT.
//   BCD_WAIT on bcd_done: res_tens/res_ones <= bcd_tens/bcd_ones -> DONE. On timeout: e=1 -> DONE.
//   DONE     update err/dp/blank masks together with the digits (single-cycle atomic update) -> IDLE.
//  e = (op_sel[1] & sub_err sampled in SETTLE) | (op_sel[3] & div_err) | timeout | illegal.
//   Any a>9 or b>9 flag is set regardless of e.
//  busy=1 in every state except IDLE. Masks and digits hold their previous values while busy (no flicker).
//  A done pulse arriving outside its WAIT state is ignored. Done coincident with timeout: done wins.
//  Latency, sw change to result for add/sub/mul: 2 (CAPTURE,SETTLE) + 2 + Tbcd + 1 cycles.
//   For div: 1 + 2 + Tdiv + 2 + Tbcd + 1 cycles.
//  Timer: 8-bit, saturating, used only in the WAIT states.
//  rst mid-operation: return to IDLE next edge; start pulses drop immediately.
// CONFIGURATION
//  `AUTO_REFRESH_EN defined: in IDLE, a REFRESH_CYC counter forces a trigger with unchanged inputs.
//   This recovers from a missed done pulse or from glitches.
//  `AUTO_REFRESH_EN undefined: evaluation only on input change; counter not built.
// STRUCTURE
//  Shared package calc_pkg: state encoding localparams, op codes OP_ADD/SUB/MUL/DIV (one-hot 4-bit),
//   TIMEOUT_CYC default.
//  Single module. The wait timer is inline (no sub-module); CNTR is not reused because the timer
//   needs clear and saturate.
// TESTING
//  1. sw=8'h34, bt=0001, bcd_done after 10 cyc with tens=0, ones=7 -> one bcd_start, no div_start; res=0,7; err_mask=0; busy falls.
//  2. sw=8'h73, bt=1000 -> div_start once; div_done after 8 cyc; bcd 2,3 -> res=2,3; dp_mask=0010.
//  3. sw=8'h50, bt=1000, div_err=1 with div_done -> err_mask=0011; dp_mask=0010.
//  4. bt=1000, div_done never asserted -> after 255 wait cycles err_mask=0011; no bcd_start; FSM back in IDLE.
//  5. sw=8'hA2, bt=0001 -> err_mask[3]=1. Then bt=0000 -> blank_mask=0011, digits 0.
//  6. sw changes during DIV_WAIT -> current op completes, then exactly one re-trigger with new value.
//     Then rst=0 during BCD_WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operation sequencer: op codes,
// FSM state encoding and default timing limits.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b1000;

  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int REFRESH_CYC_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SETTLE,
    ST_DIV_GO,
    ST_DIV_WAIT,
    ST_BCD_GO,
    ST_BCD_WAIT,
    ST_DONE
  } state_t;

  function automatic logic isOneHot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/calc_op_sequencer.sv
// Control FSM between sw/bt and the calculator datapath; runs one start/done
// handshake per evaluation. Optional feature macro: AUTO_REFRESH_EN.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int bits        = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`ifdef AUTO_REFRESH_EN
  ,
  parameter int REFRESH_CYC = REFRESH_CYC_DEF
`endif
) (
  input  logic                clk16M,
  input  logic                rst,
  input  logic [bits-1:0]     sw,
  input  logic [3:0]          bt,
  input  logic                sub_err,
  input  logic                div_err,
  input  logic                div_done,
  input  logic                bcd_done,
  input  logic [3:0]          bcd_tens,
  input  logic [3:0]          bcd_ones,
  output logic [bits/2-1:0]   op_a,
  output logic [bits/2-1:0]   op_b,
  output logic [3:0]          op_sel,
  output logic                div_start,
  output logic                bcd_start,
  output logic                busy,
  output logic [3:0]          res_tens,
  output logic [3:0]          res_ones,
  output logic [3:0]          err_mask,
  output logic [3:0]          dp_mask,
  output logic [3:0]          blank_mask
);

  localparam logic [7:0]          TimeoutVal = 8'(TIMEOUT_CYC);
  localparam logic [bits/2-1:0]   OperandMax = 9;

  state_t              state_q, state_d;
  logic [bits-1:0]     sw_q, sw_d;
  logic [3:0]          bt_q, bt_d;
  logic [bits/2-1:0]   opA_q, opA_d, opB_q, opB_d;
  logic [3:0]          opSel_q, opSel_d;
  logic [7:0]          timer_q, timer_d;
  logic                errPend_q, errPend_d;
  logic [3:0]          tensPend_q, tensPend_d, onesPend_q, onesPend_d;
  logic [3:0]          resTens_q, resTens_d, resOnes_q, resOnes_d;
  logic [3:0]          errMask_q, errMask_d, dpMask_q, dpMask_d, blankMask_q, blankMask_d;
  logic                refreshHit;
  logic                trigger;

`ifdef AUTO_REFRESH_EN
  localparam logic [7:0] RefreshLast = 8'(REFRESH_CYC - 1);
  logic [7:0] refreshCnt_q, refreshCnt_d;

  // Idle-time counter that forces a re-evaluation with unchanged inputs.
  always_comb begin
    refreshCnt_d = 8'd0;
    refreshHit   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (refreshCnt_q == RefreshLast) refreshHit = 1'b1;
      else refreshCnt_d = refreshCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk16M) begin
    if (!rst) refreshCnt_q <= 8'd0;
    else      refreshCnt_q <= refreshCnt_d;
  end
`else
  assign refreshHit = 1'b0;
`endif

  assign trigger = ({sw, bt} != {sw_q, bt_q}) || refreshHit;

  always_comb begin
    state_d     = state_q;
    sw_d        = sw_q;
    bt_d        = bt_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    opSel_d     = opSel_q;
    timer_d     = timer_q;
    errPend_d   = errPend_q;
    tensPend_d  = tensPend_q;
    onesPend_d  = onesPend_q;
    resTens_d   = resTens_q;
    resOnes_d   = resOnes_q;
    errMask_d   = errMask_q;
    dpMask_d    = dpMask_q;
    blankMask_d = blankMask_q;
    div_start   = rst && (state_q == ST_DIV_GO);
    bcd_start   = rst && (state_q == ST_BCD_GO);
    busy        = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: if (trigger) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        sw_d       = sw;
        bt_d       = bt;
        opA_d      = sw[bits-1:bits/2];
        opB_d      = sw[bits/2-1:0];
        opSel_d    = bt;
        errPend_d  = 1'b0;
        tensPend_d = 4'd0;
        onesPend_d = 4'd0;
        if (bt == 4'd0)          state_d = ST_DONE;
        else if (!isOneHot(bt)) begin
          errPend_d = 1'b1;
          state_d   = ST_DONE;
        end
        else if (bt == OP_DIV)   state_d = ST_DIV_GO;
        else                     state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (opSel_q[1] && sub_err) errPend_d = 1'b1;
        state_d = ST_BCD_GO;
      end
      ST_DIV_GO: begin
        timer_d = 8'd0;
        state_d = ST_DIV_WAIT;
      end
      // A done pulse takes priority over a timeout landing in the same cycle.
      ST_DIV_WAIT: begin
        if (div_done) begin
          if (opSel_q[3] && div_err) errPend_d = 1'b1;
          state_d = ST_BCD_GO;
        end else if (timer_q == TimeoutVal) begin
          errPend_d = 1'b1;
          state_d   = ST_DONE;
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_BCD_GO: begin
        timer_d = 8'd0;
        state_d = ST_BCD_WAIT;
      end
      ST_BCD_WAIT: begin
        if (bcd_done) begin
          tensPend_d = bcd_tens;
          onesPend_d = bcd_ones;
          state_d    = ST_DONE;
        end else if (timer_q == TimeoutVal) begin
          errPend_d = 1'b1;
          state_d   = ST_DONE;
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end
      // Digits and all masks change together so the display never shows a mix.
      ST_DONE: begin
        resTens_d   = tensPend_q;
        resOnes_d   = onesPend_q;
        errMask_d   = {opA_q > OperandMax, opB_q > OperandMax, errPend_q, errPend_q};
        dpMask_d    = {2'b00, opSel_q == OP_DIV, 1'b0};
        blankMask_d = {2'b00, opSel_q == 4'd0, opSel_q == 4'd0};
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk16M) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sw_q        <= '0;
      bt_q        <= 4'd0;
      opA_q       <= '0;
      opB_q       <= '0;
      opSel_q     <= 4'd0;
      timer_q     <= 8'd0;
      errPend_q   <= 1'b0;
      tensPend_q  <= 4'd0;
      onesPend_q  <= 4'd0;
      resTens_q   <= 4'd0;
      resOnes_q   <= 4'd0;
      errMask_q   <= 4'd0;
      dpMask_q    <= 4'd0;
      blankMask_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      sw_q        <= sw_d;
      bt_q        <= bt_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      opSel_q     <= opSel_d;
      timer_q     <= timer_d;
      errPend_q   <= errPend_d;
      tensPend_q  <= tensPend_d;
      onesPend_q  <= onesPend_d;
      resTens_q   <= resTens_d;
      resOnes_q   <= resOnes_d;
      errMask_q   <= errMask_d;
      dpMask_q    <= dpMask_d;
      blankMask_q <= blankMask_d;
    end
  end

  assign op_a       = opA_q;
  assign op_b       = opB_q;
  assign op_sel     = opSel_q;
  assign res_tens   = resTens_q;
  assign res_ones   = resOnes_q;
  assign err_mask   = errMask_q;
  assign dp_mask    = dpMask_q;
  assign blank_mask = blankMask_q;

endmodule
